wb_load_unit: RTL and testbench
===============================

Name: wb_load_unit

Overview:
- Parametrised, registered successor of the combinational write-back stage.
- Accepts one retiring instruction per cycle from MEM. Waits on a handshaked memory read response for loads.
- Extracts and sign/zero-extends load data from a DATA_W-wide bus. Merges LWL/LWR with the old rt value.
- Drives the register-file write port one cycle later and asserts stallreq while a load response is outstanding.

Parameters:
- DATA_W, 32: memory read-data width; legal values 32 or 64.
- LANE_W, $clog2(DATA_W/8): address bits used for byte-lane select (derived; do not override).
- TIMEOUT, 255: watchdog limit in cycles; used only with WB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  MEM-stage instruction valid
- in_aluop  in  `ALUOp  operation code (`ALU_* encodings)
- in_alures  in  `DataBus  ALU result for non-loads
- in_vaddr  in  `AddrBus  load virtual address
- in_rtold  in  `DataBus  current rt value, for LWL/LWR merge
- in_wreg  in  1  instruction writes a register
- in_wraddr  in  5  destination register
- m_rvalid  in  1  memory read data valid
- m_rdata  in  DATA_W  memory read data
- wb_we  out  1  register write enable (one-cycle pulse)
- wb_waddr  out  5  register write address
- wb_wdata  out  `DataBus  register write data
- stallreq  out  1  pipeline stall request
- bus_err  out  1  load timeout (WB_TIMEOUT_EN only; otherwise tied 0)

Behaviour:
- Reset values: wb_we=0, wb_waddr=0, wb_wdata=0, stallreq=0, bus_err=0, FSM=IDLE, all pending registers cleared.
- Load set: LB, LBU, LH, LHU, LW, LL, LWL, LWR. Every other aluop is a non-load.
- FSM states: IDLE, WAIT.
- Inputs are sampled only in IDLE. Upstream holds its inputs while stallreq=1.
- IDLE, in_valid and non-load:
  - Next cycle: wb_we=in_wreg, wb_waddr=in_wraddr, wb_wdata=in_alures.
  - Latency is 1 cycle.
- IDLE, in_valid, load, m_rvalid=1 in the same cycle: extract and register; wb_we next cycle. No stall.
- IDLE, in_valid, load, m_rvalid=0:
  - Capture aluop, vaddr, rtold, wreg, wraddr; go to WAIT.
  - stallreq is combinational: it is 1 in this cycle and in every WAIT cycle in which m_rvalid=0.
- WAIT, m_rvalid=1: extract from m_rdata with the captured fields; wb_we next cycle; return to IDLE. stallreq=0 in this cycle.
- m_rvalid in IDLE with no load presented: ignored.
- in_valid=0 in IDLE: wb_we=0 next cycle; wb_waddr and wb_wdata hold their previous values.
- Lane select:
  - DATA_W=64: word = m_rdata[63:32] when vaddr[2]=1, else m_rdata[31:0].
  - Within the selected word, the byte offset b=vaddr[1:0] selects the byte or halfword.
- LB/LBU: byte b, sign- or zero-extended.
- LH/LHU: b=0 selects [15:0], b=2 selects [31:16]. Misaligned (b=1,3) gives data 0 and the write still occurs.
- LW/LL: selected word unchanged.
- LWL with old value r:
  - b=0: {w[7:0], r[23:0]}
  - b=1: {w[15:0], r[15:0]}
  - b=2: {w[23:0], r[7:0]}
  - b=3: w
- LWR with old value r:
  - b=0: w
  - b=1: {r[31:24], w[31:8]}
  - b=2: {r[31:16], w[31:16]}
  - b=3: {r[31:8], w[31:24]}
- Reset mid-WAIT: the pending load is discarded; no write occurs; stallreq drops immediately (asynchronous).
- Back-to-back loads that each hit m_rvalid on first presentation produce one write per cycle.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to WAIT and increments every WAIT cycle.
  - When the count reaches TIMEOUT with no m_rvalid: bus_err pulses 1 for one cycle, wb_we=0 (no write), FSM returns to IDLE, stallreq drops.
  - An m_rvalid arriving in the same cycle as the timeout takes priority: the load completes normally.
- Undefined: no counter; WAIT persists indefinitely; bus_err tied 0.

Test Plan:
- ADDU result 0x12345678, wraddr=3, wreg=1 -> next cycle wb_we=1, waddr=3, wdata=0x12345678; stallreq never 1.
- LB vaddr=0x...1, DATA_W=32, m_rdata=0x00008000, m_rvalid same cycle -> wdata=0xFFFFFF80, no stall; LBU same inputs -> 0x00000080.
- LW, m_rvalid delayed 3 cycles, DATA_W=64, vaddr[2]=1, m_rdata=0xDEADBEEF_00000000 -> stallreq=1 for exactly 3 cycles; wdata=0xDEADBEEF one cycle after m_rvalid.
- LWL b=1, m_rdata=0xAABBCCDD, rtold=0x11223344 -> wdata=0xCCDD3344; LWR b=2, same data -> 0x1122AABB.
- Assert rst during WAIT, then release; later m_rvalid=1 -> no wb_we pulse; stallreq=0 from reset assertion onward.
- WB_TIMEOUT_EN, TIMEOUT=4, load with no m_rvalid -> bus_err one-cycle pulse after 4 WAIT cycles; wb_we stays 0; next ADDU retires normally.

Source files
------------

// File: rtl/wb_load_unit_if.sv
// Bus bundle for wb_load_unit: MEM-stage retire inputs, memory read response,
// and register-file write port / stall outputs. Also holds the shared opcode macros.
`ifndef WB_LOAD_UNIT_DEFS
`define WB_LOAD_UNIT_DEFS
`define ALUOp    7:0
`define DataBus  31:0
`define AddrBus  31:0
`define ALU_ADDU 8'b00100001
`define ALU_LB   8'b11100000
`define ALU_LBU  8'b11100100
`define ALU_LH   8'b11100001
`define ALU_LHU  8'b11100101
`define ALU_LW   8'b11100011
`define ALU_LWL  8'b11100010
`define ALU_LWR  8'b11100110
`define ALU_LL   8'b11110000
`endif

interface wb_load_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic [`ALUOp]     in_aluop;
  logic [`DataBus]   in_alures;
  logic [`AddrBus]   in_vaddr;
  logic [`DataBus]   in_rtold;
  logic              in_wreg;
  logic [4:0]        in_wraddr;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;
  logic              wb_we;
  logic [4:0]        wb_waddr;
  logic [`DataBus]   wb_wdata;
  logic              stallreq;
  logic              bus_err;

  modport master (
    output in_valid, in_aluop, in_alures, in_vaddr, in_rtold, in_wreg, in_wraddr,
    output m_rvalid, m_rdata,
    input  wb_we, wb_waddr, wb_wdata, stallreq, bus_err
  );

  modport slave (
    input  in_valid, in_aluop, in_alures, in_vaddr, in_rtold, in_wreg, in_wraddr,
    input  m_rvalid, m_rdata,
    output wb_we, wb_waddr, wb_wdata, stallreq, bus_err
  );
endinterface

// File: rtl/wb_load_unit.sv
// Registered write-back stage with load-response wait, lane extraction and LWL/LWR merge.
// Optional WB_TIMEOUT_EN adds a WAIT watchdog that aborts the load and pulses bus_err.
module wb_load_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LANE_W  = $clog2(DATA_W/8),
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  wb_load_unit_if.slave bus
);

  typedef enum logic [0:0] {IDLE, WAIT} state_t;

  state_t state, state_nx;

  logic [`ALUOp]     p_aluop;
  logic [LANE_W-1:0] p_lane;
  logic [`DataBus]   p_rtold;
  logic              p_wreg;
  logic [4:0]        p_wraddr;

  logic [`ALUOp]     cur_op;
  logic [LANE_W-1:0] cur_lane;
  logic [`DataBus]   cur_rtold;
  logic              cur_wreg;
  logic [4:0]        cur_wraddr;

  logic              accept_load, done, stall, timeout, tmo_hit;
  logic [DATA_W-1:0] rd_shift;
  logic [31:0]       word;
  logic              unused_vaddr;

  assign unused_vaddr = ^bus.in_vaddr[31:LANE_W];

  function automatic logic is_load(input logic [`ALUOp] op);
    case (op)
      `ALU_LB, `ALU_LBU, `ALU_LH, `ALU_LHU,
      `ALU_LW, `ALU_LL, `ALU_LWL, `ALU_LWR: is_load = 1'b1;
      default:                             is_load = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [`ALUOp] op, input logic [1:0] b,
                                          input logic [31:0] w, input logic [31:0] r);
    logic [7:0]  byt;
    logic [15:0] half;
    byt  = w[{b, 3'b000} +: 8];
    half = b[1] ? w[31:16] : w[15:0];
    case (op)
      `ALU_LB:  extract = {{24{byt[7]}}, byt};
      `ALU_LBU: extract = {24'h0, byt};
      `ALU_LH:  extract = b[0] ? '0 : {{16{half[15]}}, half};
      `ALU_LHU: extract = b[0] ? '0 : {16'h0, half};
      `ALU_LWL:
        case (b)
          2'd0:    extract = {w[7:0],  r[23:0]};
          2'd1:    extract = {w[15:0], r[15:0]};
          2'd2:    extract = {w[23:0], r[7:0]};
          default: extract = w;
        endcase
      `ALU_LWR:
        case (b)
          2'd0:    extract = w;
          2'd1:    extract = {r[31:24], w[31:8]};
          2'd2:    extract = {r[31:16], w[31:16]};
          default: extract = {r[31:8],  w[31:24]};
        endcase
      default:  extract = w;
    endcase
  endfunction

  // In WAIT the captured fields drive extraction; upstream inputs are ignored.
  always_comb begin
    if (state == WAIT) begin
      cur_op     = p_aluop;
      cur_lane   = p_lane;
      cur_rtold  = p_rtold;
      cur_wreg   = p_wreg;
      cur_wraddr = p_wraddr;
    end else begin
      cur_op     = bus.in_aluop;
      cur_lane   = bus.in_vaddr[LANE_W-1:0];
      cur_rtold  = bus.in_rtold;
      cur_wreg   = bus.in_wreg;
      cur_wraddr = bus.in_wraddr;
    end
  end

  assign rd_shift = bus.m_rdata >> {cur_lane >> 2, 5'b00000};
  assign word     = rd_shift[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept_load)      state_nx = WAIT;
      WAIT: if (done || timeout)  state_nx = IDLE;
    endcase
  end

  // A watchdog expiry drops stall in the same cycle so upstream retires the failed load.
  always_comb begin
    accept_load = 1'b0;
    done        = 1'b0;
    stall       = 1'b0;
    timeout     = 1'b0;
    unique case (state)
      IDLE:
        if (bus.in_valid) begin
          if (!is_load(bus.in_aluop) || bus.m_rvalid) done = 1'b1;
          else begin
            accept_load = 1'b1;
            stall       = 1'b1;
          end
        end
      WAIT:
        if (bus.m_rvalid) done    = 1'b1;
        else if (tmo_hit) timeout = 1'b1;
        else              stall   = 1'b1;
    endcase
  end

  assign bus.stallreq = stall & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wb_we    <= 1'b0;
      bus.wb_waddr <= '0;
      bus.wb_wdata <= '0;
      p_aluop      <= '0;
      p_lane       <= '0;
      p_rtold      <= '0;
      p_wreg       <= 1'b0;
      p_wraddr     <= '0;
    end else begin
      bus.wb_we <= done & cur_wreg;
      if (done) begin
        bus.wb_waddr <= cur_wraddr;
        bus.wb_wdata <= is_load(cur_op) ? extract(cur_op, cur_lane[1:0], word, cur_rtold)
                                        : bus.in_alures;
      end
      if (accept_load) begin
        p_aluop  <= bus.in_aluop;
        p_lane   <= bus.in_vaddr[LANE_W-1:0];
        p_rtold  <= bus.in_rtold;
        p_wreg   <= bus.in_wreg;
        p_wraddr <= bus.in_wraddr;
      end
    end
  end

`ifdef WB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;

  // Count reaches TIMEOUT on the TIMEOUT-th WAIT cycle.
  assign tmo_hit     = (tmo_cnt == CNT_W'(TIMEOUT - 1));
  assign bus.bus_err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= timeout;
      if (accept_load)        tmo_cnt <= '0;
      else if (state == WAIT) tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign tmo_hit        = 1'b0;
  assign bus.bus_err    = 1'b0;
`endif

endmodule

// File: tb/tb_wb_load_unit.sv
// Directed bench for wb_load_unit (DATA_W=64): expected writes are queued at issue
// and compared by a negedge monitor as wb_we pulses appear.
`ifndef WB_LOAD_UNIT_DEFS
`define WB_LOAD_UNIT_DEFS
`define ALUOp    7:0
`define DataBus  31:0
`define AddrBus  31:0
`define ALU_ADDU 8'b00100001
`define ALU_LB   8'b11100000
`define ALU_LBU  8'b11100100
`define ALU_LH   8'b11100001
`define ALU_LHU  8'b11100101
`define ALU_LW   8'b11100011
`define ALU_LWL  8'b11100010
`define ALU_LWR  8'b11100110
`define ALU_LL   8'b11110000
`endif

module tb_wb_load_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_load_unit_if #(.DATA_W(64)) bus ();

  wb_load_unit #(.DATA_W(64), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         expq[$];
  wr_t         mon_e;
  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned stall_cycles = 0;
  int unsigned s0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    expq.push_back(wr_t'{a, d});
  endtask

  task automatic set_in(input logic v, input logic [7:0] op, input logic [31:0] alures,
                        input logic [31:0] vaddr, input logic [31:0] rtold,
                        input logic [4:0] wraddr, input logic rv, input logic [63:0] rdata);
    bus.in_valid  = v;
    bus.in_aluop  = op;
    bus.in_alures = alures;
    bus.in_vaddr  = vaddr;
    bus.in_rtold  = rtold;
    bus.in_wreg   = 1'b1;
    bus.in_wraddr = wraddr;
    bus.m_rvalid  = rv;
    bus.m_rdata   = rdata;
  endtask

  task automatic quiet();
    set_in(1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 64'h0);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.stallreq === 1'b1) stall_cycles++;
      if (bus.wb_we !== 1'b0) begin
        if (expq.size() == 0) check("unexpected_write", 64'(bus.wb_we), 64'h0);
        else begin
          mon_e = expq.pop_front();
          check("waddr", 64'(bus.wb_waddr), 64'(mon_e.a));
          check("wdata", 64'(bus.wb_wdata), 64'(mon_e.d));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    quiet();
    #12;
    check("rst_we",     64'(bus.wb_we),    64'h0);
    check("rst_waddr",  64'(bus.wb_waddr), 64'h0);
    check("rst_wdata",  64'(bus.wb_wdata), 64'h0);
    check("rst_stall",  64'(bus.stallreq), 64'h0);
    check("rst_buserr", 64'(bus.bus_err),  64'h0);
    @(negedge clk);
    rst = 1'b0;

    // ADDU, one-cycle latency
    nxt();
    set_in(1'b1, `ALU_ADDU, 32'h12345678, 32'h0, 32'h0, 5'd3, 1'b0, 64'h0);
    expect_wr(5'd3, 32'h12345678);
    #2 check("addu_stall", 64'(bus.stallreq), 64'h0);

    // back-to-back LB / LBU with immediate response, low lane
    nxt();
    set_in(1'b1, `ALU_LB, 32'h0, 32'h10000001, 32'h0, 5'd5, 1'b1, {32'hCAFEF00D, 32'h00008000});
    expect_wr(5'd5, 32'hFFFFFF80);
    #2 check("lb_stall", 64'(bus.stallreq), 64'h0);
    nxt();
    set_in(1'b1, `ALU_LBU, 32'h0, 32'h10000001, 32'h0, 5'd6, 1'b1, {32'hCAFEF00D, 32'h00008000});
    expect_wr(5'd6, 32'h00000080);
    #2 check("lbu_stall", 64'(bus.stallreq), 64'h0);

    // stray m_rvalid with no load, then idle: outputs hold, no write
    nxt();
    set_in(1'b0, `ALU_LW, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    nxt();
    quiet();
    nxt();
    check("hold_we",    64'(bus.wb_we),    64'h0);
    check("hold_waddr", 64'(bus.wb_waddr), 64'd6);
    check("hold_wdata", 64'(bus.wb_wdata), 64'h00000080);

    // LW with response 3 cycles late, upper lane
    s0 = stall_cycles;
    set_in(1'b1, `ALU_LW, 32'h0, 32'h20000004, 32'h0, 5'd7, 1'b0, 64'h0);
    #2 check("lw_stall_idle", 64'(bus.stallreq), 64'h1);
    nxt();
    #2 check("lw_stall_wait", 64'(bus.stallreq), 64'h1);
    nxt();
    nxt();
    bus.in_valid = 1'b0;
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 64'hDEADBEEF_00000000;
    expect_wr(5'd7, 32'hDEADBEEF);
    #2 check("lw_stall_resp", 64'(bus.stallreq), 64'h0);
    nxt();
    quiet();
    check("lw_stall_count", 64'(stall_cycles - s0), 64'd3);

    // merge and halfword cases, all with immediate response
    set_in(1'b1, `ALU_LWL, 32'h0, 32'h1, 32'h11223344, 5'd8, 1'b1, {32'h0, 32'hAABBCCDD});
    expect_wr(5'd8, 32'hCCDD3344);
    nxt();
    set_in(1'b1, `ALU_LWR, 32'h0, 32'h2, 32'h11223344, 5'd9, 1'b1, {32'h0, 32'hAABBCCDD});
    expect_wr(5'd9, 32'h1122AABB);
    nxt();
    set_in(1'b1, `ALU_LH, 32'h0, 32'h2, 32'h0, 5'd10, 1'b1, {32'h0, 32'hAABBCCDD});
    expect_wr(5'd10, 32'hFFFFAABB);
    nxt();
    set_in(1'b1, `ALU_LH, 32'h0, 32'h1, 32'h0, 5'd11, 1'b1, {32'h0, 32'hAABBCCDD});
    expect_wr(5'd11, 32'h00000000);
    nxt();
    set_in(1'b1, `ALU_LHU, 32'h0, 32'h0, 32'h0, 5'd12, 1'b1, {32'h0, 32'hAABBCCDD});
    expect_wr(5'd12, 32'h0000CCDD);
    nxt();
    set_in(1'b1, `ALU_LWL, 32'h0, 32'h6, 32'h11223344, 5'd13, 1'b1, {32'h55667788, 32'h0});
    expect_wr(5'd13, 32'h66778844);
    nxt();
    set_in(1'b1, `ALU_LB, 32'h0, 32'h7, 32'h0, 5'd14, 1'b1, {32'h55667788, 32'h0});
    expect_wr(5'd14, 32'h00000055);
    nxt();
    quiet();
    nxt();

    // reset while a load is pending: no write afterwards
    set_in(1'b1, `ALU_LW, 32'h0, 32'h0, 32'h0, 5'd15, 1'b0, 64'h0);
    nxt();
    bus.in_valid = 1'b0;
    #2 check("rstw_stall_before", 64'(bus.stallreq), 64'h1);
    #1 rst = 1'b1;
    #1 check("rstw_stall_drop", 64'(bus.stallreq), 64'h0);
    nxt();
    #3 rst = 1'b0;
    nxt();
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 64'h12345678_9ABCDEF0;
    #2 check("rstw_stall_after", 64'(bus.stallreq), 64'h0);
    nxt();
    quiet();
    nxt();
    check("rstw_no_write", 64'(bus.wb_we), 64'h0);
    check("rstw_waddr",    64'(bus.wb_waddr), 64'h0);

    // normal retirement after reset
    set_in(1'b1, `ALU_ADDU, 32'h0000A5A5, 32'h0, 32'h0, 5'd16, 1'b0, 64'h0);
    expect_wr(5'd16, 32'h0000A5A5);
    nxt();
    quiet();

`ifdef WB_TIMEOUT_EN
    nxt();
    set_in(1'b1, `ALU_LW, 32'h0, 32'h0, 32'h0, 5'd17, 1'b0, 64'h0);
    nxt();
    bus.in_valid = 1'b0;
    nxt();
    nxt();
    nxt();
    #2 check("tmo_err_early", 64'(bus.bus_err), 64'h0);
    check("tmo_stall_drop", 64'(bus.stallreq), 64'h0);
    nxt();
    #2 check("tmo_err_pulse", 64'(bus.bus_err), 64'h1);
    check("tmo_no_write", 64'(bus.wb_we), 64'h0);
    nxt();
    #2 check("tmo_err_clear", 64'(bus.bus_err), 64'h0);
    set_in(1'b1, `ALU_ADDU, 32'h00C0FFEE, 32'h0, 32'h0, 5'd18, 1'b0, 64'h0);
    expect_wr(5'd18, 32'h00C0FFEE);
    nxt();
    quiet();
`endif

    for (int i = 0; i < 10 && expq.size() != 0; i++) nxt();
    nxt();
    check("queue_drained", 64'(expq.size()), 64'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
